sysver_axil_reader: RTL and testbench

// AXI4-lite read master (initiator) that fetches the FPGA_VER (0x0) and BOARD (0x4) registers

---
 rtl/sysver_pkg.sv | 38 +++
 rtl/sysver_axil_reader.sv | 161 ++++++++++++++++
 tb/tb_sysver_axil_reader.sv | 383 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sysver_pkg.sv
// Shared constants for the system version reader: register map, field layout, codes, FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sysver_pkg;

  // Register offsets within the system version responder
  localparam int unsigned REG_FPGA_VER = 32'h0;
  localparam int unsigned REG_BOARD    = 32'h4;

  // FPGA_VER field layout
  localparam int VER_MAJ_OFF   = 24;
  localparam int VER_MAJ_W     = 8;
  localparam int VER_MIN_OFF   = 16;
  localparam int VER_MIN_W     = 8;
  localparam int VER_BUILD_OFF = 0;
  localparam int VER_BUILD_W   = 16;

  // BOARD field offsets (widths are parameters of the reader)
  localparam int BOARD_TYPE_OFF = 16;
  localparam int BOARD_REV_OFF  = 0;

  // AXI read response code
  localparam logic [1:0] RESP_OKAY = 2'b00;

  // Error codes reported on err
  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_RESP    = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_DRAIN_A,
    ST_DRAIN_R
  } state_t;

endpackage

// File: rtl/sysver_axil_reader.sv
// AXI4-lite read master: fetches FPGA_VER then BOARD and publishes decoded fields atomically.
// Latency: 4 cycles start-to-done with a zero-wait responder, plus every responder wait cycle.
// Backpressure: holds arvalid/araddr until accepted; per-phase timeout, then drains the open transfer.
module sysver_axil_reader
  import sysver_pkg::*;
#(
  parameter int                            C_M_AXI_ADDR_WIDTH = 32,
  parameter int                            C_M_AXI_DATA_WIDTH = 32,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR        = '0,
  parameter int                            C_BOARD_TYPE_WIDTH = 4,
  parameter int                            C_BOARD_REV_WIDTH  = 4,
  parameter int                            C_TIMEOUT_CYCLES   = 1024,
  parameter int                            C_AUTO_START       = 1
) (
  input  logic                          m_axi_aclk,
  input  logic                          m_axi_areset,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [2:0]                    m_axi_arprot,
  output logic                          m_axi_arvalid,
  input  logic                          m_axi_arready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]                    m_axi_rresp,
  input  logic                          m_axi_rvalid,
  output logic                          m_axi_rready,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic [1:0]                    err,
  output logic [7:0]                    ver_maj,
  output logic [7:0]                    ver_min,
  output logic [15:0]                   ver_build,
  output logic [C_BOARD_TYPE_WIDTH-1:0] board_type,
  output logic [C_BOARD_REV_WIDTH-1:0]  board_rev
);

  localparam int TCW = (C_TIMEOUT_CYCLES > 2) ? $clog2(C_TIMEOUT_CYCLES) : 1;
  localparam logic [TCW-1:0] TMAX = TCW'(C_TIMEOUT_CYCLES - 1);

  localparam logic [C_M_AXI_ADDR_WIDTH-1:0] ADDR_VER =
    C_BASE_ADDR + C_M_AXI_ADDR_WIDTH'(REG_FPGA_VER);
  localparam logic [C_M_AXI_ADDR_WIDTH-1:0] ADDR_BOARD =
    C_BASE_ADDR + C_M_AXI_ADDR_WIDTH'(REG_BOARD);

  state_t                          state;
  logic                            idx;        // 0 = FPGA_VER, 1 = BOARD
  logic                            auto_pend;  // one-shot start request armed by reset
  logic [TCW-1:0]                  tcnt;
  logic [C_M_AXI_DATA_WIDTH-1:0]   shadow_ver; // FPGA_VER held until BOARD also succeeds

  assign m_axi_arprot = 3'b000;

  // Read sequencer: two single-beat reads, per-phase timeout, atomic field commit.
  always_ff @(posedge m_axi_aclk) begin
    if (m_axi_areset) begin
      state         <= ST_IDLE;
      idx           <= 1'b0;
      auto_pend     <= (C_AUTO_START != 0);
      tcnt          <= '0;
      shadow_ver    <= '0;
      m_axi_araddr  <= '0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= ERR_OK;
      ver_maj       <= '0;
      ver_min       <= '0;
      ver_build     <= '0;
      board_type    <= '0;
      board_rev     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start || auto_pend) begin
            auto_pend     <= 1'b0;
            idx           <= 1'b0;
            done          <= 1'b0;
            err           <= ERR_OK;
            busy          <= 1'b1;
            m_axi_araddr  <= ADDR_VER;
            m_axi_arvalid <= 1'b1;
            tcnt          <= '0;
            state         <= ST_ADDR;
          end
        end

        ST_ADDR: begin
          if (m_axi_arvalid && m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
            tcnt          <= '0;
            state         <= ST_DATA;
          end else if (tcnt == TMAX) begin
            // arvalid stays up: an issued request cannot be withdrawn
            err   <= ERR_TIMEOUT;
            done  <= 1'b1;
            state <= ST_DRAIN_A;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end

        ST_DATA: begin
          if (m_axi_rvalid && m_axi_rready) begin
            m_axi_rready <= 1'b0;
            if (m_axi_rresp != RESP_OKAY) begin
              // published fields keep the last fully good values
              err   <= ERR_RESP;
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= ST_IDLE;
            end else if (idx == 1'b0) begin
              shadow_ver    <= m_axi_rdata;
              idx           <= 1'b1;
              m_axi_araddr  <= ADDR_BOARD;
              m_axi_arvalid <= 1'b1;
              tcnt          <= '0;
              state         <= ST_ADDR;
            end else begin
              // BOARD goes straight from rdata; both registers land in one cycle
              ver_maj    <= shadow_ver[VER_MAJ_OFF +: VER_MAJ_W];
              ver_min    <= shadow_ver[VER_MIN_OFF +: VER_MIN_W];
              ver_build  <= shadow_ver[VER_BUILD_OFF +: VER_BUILD_W];
              board_type <= m_axi_rdata[BOARD_TYPE_OFF +: C_BOARD_TYPE_WIDTH];
              board_rev  <= m_axi_rdata[BOARD_REV_OFF +: C_BOARD_REV_WIDTH];
              done       <= 1'b1;
              busy       <= 1'b0;
              state      <= ST_IDLE;
            end
          end else if (tcnt == TMAX) begin
            err   <= ERR_TIMEOUT;
            done  <= 1'b1;
            state <= ST_DRAIN_R;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end

        ST_DRAIN_A: begin
          if (m_axi_arvalid && m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
            state         <= ST_DRAIN_R;
          end
        end

        ST_DRAIN_R: begin
          // the late response is swallowed so the responder is left clean
          if (m_axi_rvalid && m_axi_rready) begin
            m_axi_rready <= 1'b0;
            busy         <= 1'b0;
            state        <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sysver_axil_reader.sv
// Bench for sysver_axil_reader: randomized register contents and responder waits vs. a field model.
// Latency: checks start-to-done cycle counts against 4 + 2*ar_wait + 2*r_wait.
// Backpressure: responder can stall arready/rvalid indefinitely to exercise timeout and drain.
module tb_sysver_axil_reader;

  localparam int T = 16;

  logic        clk = 1'b0;
  logic        areset = 1'b1;
  logic        start = 1'b1;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready = 1'b0;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = 2'b00;
  logic        rvalid = 1'b0;
  logic        rready;
  logic        busy, done;
  logic [1:0]  err;
  logic [7:0]  ver_maj, ver_min;
  logic [15:0] ver_build;
  logic [3:0]  board_type, board_rev;

  // responder configuration
  logic [31:0] ver_reg = 32'h0102_0007;
  logic [31:0] board_reg = 32'h0003_0002;
  logic [1:0]  ver_resp = 2'b00;
  logic [1:0]  board_resp = 2'b00;
  int          ar_wait = 0;
  int          r_wait = 0;
  bit          ar_block = 0;
  bit          r_block = 0;

  // observation
  int          n_ar = 0;
  int          ar_viol = 0;
  logic [31:0] ar_log[$];
  logic [31:0] rq[$];

  // reference model of the published fields
  int unsigned m_maj = 0, m_min = 0, m_build = 0, m_type = 0, m_rev = 0;

  int n_cmp = 0;
  int n_mis = 0;

  sysver_axil_reader #(
    .C_M_AXI_ADDR_WIDTH(32),
    .C_M_AXI_DATA_WIDTH(32),
    .C_BASE_ADDR       (32'h0),
    .C_BOARD_TYPE_WIDTH(4),
    .C_BOARD_REV_WIDTH (4),
    .C_TIMEOUT_CYCLES  (T),
    .C_AUTO_START      (1)
  ) dut (
    .m_axi_aclk   (clk),
    .m_axi_areset (areset),
    .m_axi_araddr (araddr),
    .m_axi_arprot (arprot),
    .m_axi_arvalid(arvalid),
    .m_axi_arready(arready),
    .m_axi_rdata  (rdata),
    .m_axi_rresp  (rresp),
    .m_axi_rvalid (rvalid),
    .m_axi_rready (rready),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .ver_maj      (ver_maj),
    .ver_min      (ver_min),
    .ver_build    (ver_build),
    .board_type   (board_type),
    .board_rev    (board_rev)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // Responder: observe handshakes on the rising edge, drive channel inputs on the falling edge.
  initial begin : responder
    bit          ar_hs_now;
    bit          r_hs_now;
    bit          prev_pending;
    logic [31:0] prev_addr;
    int          ar_cnt;
    int          r_cnt;
    prev_pending = 0;
    prev_addr = '0;
    ar_cnt = 0;
    r_cnt = 0;
    forever begin
      @(posedge clk);
      ar_hs_now = 0;
      r_hs_now = 0;
      if (areset) begin
        prev_pending = 0;
      end else begin
        ar_hs_now = arvalid && arready;
        r_hs_now = rvalid && rready;
        if (prev_pending && (!arvalid || araddr != prev_addr)) ar_viol++;
        prev_pending = arvalid && !arready;
        prev_addr = araddr;
        if (ar_hs_now) begin
          n_ar++;
          ar_log.push_back(araddr);
          rq.push_back(araddr);
        end
        if (r_hs_now && rq.size() > 0) void'(rq.pop_front());
      end
      @(negedge clk);
      if (areset) begin
        arready = 0;
        rvalid = 0;
        ar_cnt = 0;
        r_cnt = 0;
        rq.delete();
      end else begin
        if (ar_hs_now || !arvalid || ar_block) begin
          arready = 0;
          ar_cnt = 0;
        end else if (ar_cnt >= ar_wait) begin
          arready = 1;
        end else begin
          arready = 0;
          ar_cnt++;
        end
        if (r_hs_now || rq.size() == 0 || r_block) begin
          rvalid = 0;
          r_cnt = 0;
        end else if (r_cnt >= r_wait) begin
          rvalid = 1;
          rdata = (rq[0] == 32'h4) ? board_reg : ver_reg;
          rresp = (rq[0] == 32'h4) ? board_resp : ver_resp;
        end else begin
          rvalid = 0;
          r_cnt++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_mis++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_commit(input logic [31:0] v, input logic [31:0] b);
    m_maj   = v / 32'h0100_0000;
    m_min   = (v / 32'h0001_0000) % 256;
    m_build = v % 65536;
    m_type  = (b / 65536) % 16;
    m_rev   = b % 16;
  endtask

  task automatic check_fields(input string tag);
    check({tag, ".maj"},   ver_maj,    m_maj);
    check({tag, ".min"},   ver_min,    m_min);
    check({tag, ".build"}, ver_build,  m_build);
    check({tag, ".type"},  board_type, m_type);
    check({tag, ".rev"},   board_rev,  m_rev);
  endtask

  // Edges until done is seen; -1 when the bound expires.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int n = 1; n <= 400; n++) begin
      tick();
      if (done === 1'b1) begin
        lat = n;
        return;
      end
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 0;
    for (int n = 1; n <= 400; n++) begin
      tick();
      if (busy === 1'b0) begin
        ok = 1;
        return;
      end
    end
  endtask

  // Pulse start for one sampling edge and return the edge count until done.
  task automatic run_seq(output int lat);
    int l;
    start = 1;
    tick();
    start = 0;
    wait_done(l);
    lat = (l < 0) ? -1 : l;
  endtask

  initial begin : main
    int lat;
    bit ok;
    int n0;

    // reset with start asserted: reset must win
    tick();
    tick();
    check("rst.arvalid", arvalid, 0);
    check("rst.rready",  rready,  0);
    check("rst.araddr",  araddr,  0);
    check("rst.busy",    busy,    0);
    check("rst.done",    done,    0);
    check("rst.err",     err,     0);
    check("rst.arprot",  arprot,  0);
    check_fields("rst");

    // auto-start on the first cycle after reset
    start = 0;
    areset = 0;
    model_commit(ver_reg, board_reg);
    wait_done(lat);
    check("auto.lat",  lat,  5);
    check("auto.err",  err,  0);
    check("auto.busy", busy, 0);
    check("auto.nar",  n_ar, 2);
    check("auto.addr0", ar_log[0], 32'h0);
    check("auto.addr1", ar_log[1], 32'h4);
    check_fields("auto");

    // slow responder: two extra cycles on every phase
    ar_wait = 2;
    r_wait = 2;
    ver_reg = $urandom;
    board_reg = $urandom;
    run_seq(lat);
    model_commit(ver_reg, board_reg);
    check("slow.lat", lat, 12);
    check("slow.err", err, 0);
    check("slow.addr", {ar_log[ar_log.size()-2], ar_log[ar_log.size()-1]}, {32'h0, 32'h4});
    check_fields("slow");

    // randomized contents and waits
    for (int i = 0; i < 6; i++) begin
      ar_wait = $urandom_range(0, 3);
      r_wait = $urandom_range(0, 3);
      ver_reg = $urandom;
      board_reg = $urandom;
      run_seq(lat);
      model_commit(ver_reg, board_reg);
      check($sformatf("rnd%0d.lat", i), lat, 4 + 2 * ar_wait + 2 * r_wait);
      check($sformatf("rnd%0d.err", i), err, 0);
      check_fields($sformatf("rnd%0d", i));
    end

    // BOARD read answers SLVERR: fields keep prior values
    ar_wait = 0;
    r_wait = 0;
    ver_reg = $urandom;
    board_reg = $urandom;
    board_resp = 2'b10;
    run_seq(lat);
    check("slverr.lat",  lat,  4);
    check("slverr.err",  err,  1);
    check("slverr.busy", busy, 0);
    check("slverr.addr", ar_log[ar_log.size()-1], 32'h4);
    check_fields("slverr");
    board_resp = 2'b00;

    // FPGA_VER read answers DECERR: BOARD is never requested
    ver_resp = 2'b11;
    n0 = n_ar;
    run_seq(lat);
    check("decerr.lat", lat, 2);
    check("decerr.err", err, 1);
    check("decerr.nar", n_ar - n0, 1);
    check_fields("decerr");
    ver_resp = 2'b00;

    // address phase timeout: arvalid held until accepted, then drain
    ar_block = 1;
    start = 1;
    tick();
    start = 0;
    for (int k = 1; k < T; k++) tick();
    check("toa.err_before", err, 0);
    check("toa.done_before", done, 0);
    tick();
    check("toa.err", err, 2);
    check("toa.done", done, 1);
    check("toa.busy", busy, 1);
    check("toa.arvalid", arvalid, 1);
    tick();
    tick();
    tick();
    check("toa.arvalid_hold", arvalid, 1);
    ar_block = 0;
    wait_idle(ok);
    check("toa.drained", ok, 1);
    check("toa.err_after", err, 2);
    check_fields("toa");

    // data phase timeout: done at T cycles into DATA, busy until drained
    r_block = 1;
    run_seq(lat);
    check("tor.lat", lat, T + 1);
    check("tor.err", err, 2);
    check("tor.busy", busy, 1);
    check("tor.rready", rready, 1);
    r_block = 0;
    wait_idle(ok);
    check("tor.drained", ok, 1);
    check_fields("tor");

    // start while busy is ignored
    ver_reg = $urandom;
    board_reg = $urandom;
    n0 = n_ar;
    start = 1;
    tick();
    start = 0;
    tick();
    start = 1;
    tick();
    start = 0;
    wait_done(lat);
    for (int k = 0; k < 10; k++) tick();
    model_commit(ver_reg, board_reg);
    check("busy_start.nar", n_ar - n0, 2);
    check("busy_start.busy", busy, 0);
    check("busy_start.err", err, 0);
    check_fields("busy_start");

    // reset while in the data phase
    r_wait = 6;
    start = 1;
    tick();
    start = 0;
    tick();
    tick();
    check("mid.rready_pre", rready, 1);
    areset = 1;
    tick();
    m_maj = 0;
    m_min = 0;
    m_build = 0;
    m_type = 0;
    m_rev = 0;
    check("mid.arvalid", arvalid, 0);
    check("mid.rready", rready, 0);
    check("mid.busy", busy, 0);
    check("mid.done", done, 0);
    check("mid.err", err, 0);
    check_fields("mid");
    tick();
    r_wait = 0;
    ver_reg = $urandom;
    board_reg = $urandom;
    areset = 0;
    wait_done(lat);
    model_commit(ver_reg, board_reg);
    check("mid.relat", lat, 5);
    check("mid.reerr", err, 0);
    check_fields("mid_re");

    // address must never change or drop while waiting for arready
    check("ar.stable", ar_viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
